// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan multiplexer.
package seg_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    typedef logic [3:0] nibble_t;

    // Wide all-ones pattern; users slice it down to their anode count.
    localparam logic [63:0] ANODE_OFF = '1;

endpackage

// File: rtl/seg_slot_timer.sv
// Free-running slot counter: PRESCALE clocks per digit slot, with strobes
// marking the last blank cycle and the last cycle of the slot.
module seg_slot_timer #(
    parameter int PRESCALE  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic blank_done,
    output logic slot_done
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(PRESCALE - 1);

    if (BLANK_CYC < 1 || PRESCALE <= BLANK_CYC) begin : g_param_err
        $error("seg_slot_timer: need BLANK_CYC >= 1 and PRESCALE > BLANK_CYC");
    end

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        blank_done = (cnt_q == BLANK_LAST);
        slot_done  = (cnt_q == SLOT_LAST);
        cnt_d      = slot_done ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-segment digit scanner with double-buffered display value.
// Define SEG_LZB_EN to enable leading-zero blanking.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int PRESCALE  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] data_i,
    input  logic                  load_i,
    output logic [3:0]            nib_o,
    output logic [N_DIGITS-1:0]   an_o,
    output logic                  blank_o,
    output logic                  frame_o
);

    localparam int DATA_W = 4 * N_DIGITS;
    localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] AN_IDLE  = ANODE_OFF[N_DIGITS-1:0];

    if (BLANK_CYC < 1 || PRESCALE <= BLANK_CYC || N_DIGITS < 1) begin : g_param_err
        $error("seg_scan_mux: illegal N_DIGITS/PRESCALE/BLANK_CYC combination");
    end

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   active_q, active_d;
    logic [DATA_W-1:0]   shadow_q, shadow_d;
    logic                pend_q, pend_d;
    nibble_t             nib_q, nib_d;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic                blank_q, blank_d;
    logic                frame_q, frame_d;

    logic                blank_done;
    logic                slot_done;
    logic                wrap;
    nibble_t             digits [N_DIGITS];
    logic [N_DIGITS-1:0] suppress;
`ifdef SEG_LZB_EN
    logic                zero_above;
`endif

    seg_slot_timer #(
        .PRESCALE  (PRESCALE),
        .BLANK_CYC (BLANK_CYC)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .blank_done (blank_done),
        .slot_done  (slot_done)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wrap    = 1'b0;
        case (state_q)
            ST_BLANK: begin
                if (blank_done) begin
                    state_d = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (slot_done) begin
                    state_d = ST_BLANK;
                    wrap    = (idx_q == IDX_LAST);
                    idx_d   = wrap ? '0 : idx_q + 1'b1;
                end
            end
            default: state_d = ST_BLANK;
        endcase
    end

    // The displayed value only changes at the frame boundary, so a frame never tears.
    always_comb begin
        active_d = active_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        if (wrap) begin
            pend_d = 1'b0;
            if (load_i) begin
                active_d = data_i;
            end else if (pend_q) begin
                active_d = shadow_q;
            end
        end else if (load_i) begin
            shadow_d = data_i;
            pend_d   = 1'b1;
        end
    end

    for (genvar k = 0; k < N_DIGITS; k++) begin : g_digits
        assign digits[k] = active_d[4*k +: 4];
    end

`ifdef SEG_LZB_EN
    always_comb begin
        zero_above = 1'b1;
        suppress   = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above & (digits[k] == 4'h0);
            if (k > 0) begin
                suppress[k] = zero_above;
            end
        end
    end
`else
    always_comb begin
        suppress = '0;
    end
`endif

    // Outputs are decoded from next-state values so the registers track the FSM with no lag.
    always_comb begin
        nib_d   = digits[idx_d];
        an_d    = AN_IDLE;
        blank_d = 1'b1;
        frame_d = wrap;
        if (state_d == ST_SHOW && !suppress[idx_d]) begin
            an_d[idx_d] = 1'b0;
            blank_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_BLANK;
            idx_q    <= '0;
            active_q <= '0;
            shadow_q <= '0;
            pend_q   <= 1'b0;
            nib_q    <= '0;
            an_q     <= AN_IDLE;
            blank_q  <= 1'b1;
            frame_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            active_q <= active_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            nib_q    <= nib_d;
            an_q     <= an_d;
            blank_q  <= blank_d;
            frame_q  <= frame_d;
        end
    end

    assign nib_o   = nib_q;
    assign an_o    = an_q;
    assign blank_o = blank_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux: constant vector table, hand-written
// corner sequences, and randomized loads checked against a cycle-count model.
module tb_seg_scan_mux;

    localparam int N     = 4;
    localparam int P     = 8;
    localparam int B     = 2;
    localparam int FRAME = N * P;
`ifdef SEG_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic [15:0] data_i = 16'h0;
    logic        load_i = 1'b0;
    logic [3:0]  nib_o;
    logic [3:0]  an_o;
    logic        blank_o;
    logic        frame_o;

    seg_scan_mux #(
        .N_DIGITS  (N),
        .PRESCALE  (P),
        .BLANK_CYC (B)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_i  (data_i),
        .load_i  (load_i),
        .nib_o   (nib_o),
        .an_o    (an_o),
        .blank_o (blank_o),
        .frame_o (frame_o)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          t     = 0;
    logic [15:0] m_active = 16'h0;
    logic [15:0] m_shadow = 16'h0;
    bit          m_pend   = 1'b0;

    typedef struct {
        int          cyc;
        logic        ld;
        logic [15:0] d;
        logic [3:0]  nib;
        logic [3:0]  an;
        logic        blank;
        logic        frame;
        string       name;
    } vec_t;

    vec_t vecs[$];

    // Expected outputs from cycle count since reset and the displayed value.
    function automatic logic [9:0] model_out(input int tc, input logic [15:0] a);
        int          idx;
        int          ph;
        logic [15:0] upper;
        logic [3:0]  nib;
        logic [3:0]  an;
        logic        blank;
        logic        frame;
        idx   = (tc / P) % N;
        ph    = tc % P;
        upper = a >> (4 * idx);
        nib   = upper[3:0];
        blank = (ph < B) || (LZB && idx > 0 && upper == 16'h0);
        an    = blank ? 4'hF : ~(4'b0001 << idx);
        frame = (tc > 0) && (tc % FRAME == 0);
        return {nib, an, blank, frame};
    endfunction

    function automatic logic [9:0] dut_out();
        return {nib_o, an_o, blank_o, frame_o};
    endfunction

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s t=%0d got nib=%h an=%b blank=%b frame=%b, want nib=%h an=%b blank=%b frame=%b",
                     name, t, act[9:6], act[5:2], act[1], act[0], exp[9:6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    task automatic tick(input logic ld, input logic [15:0] d);
        load_i = ld;
        data_i = d;
        @(posedge clk);
        if (t % FRAME == FRAME - 1) begin
            if (ld) begin
                m_active = d;
            end else if (m_pend) begin
                m_active = m_shadow;
            end
            m_pend = 1'b0;
        end else if (ld) begin
            m_shadow = d;
            m_pend   = 1'b1;
        end
        t++;
        #1;
        load_i = 1'b0;
        check("model", dut_out(), model_out(t, m_active));
    endtask

    task automatic do_reset(input int n);
        rst_n  = 1'b0;
        load_i = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            check("reset", dut_out(), {4'h0, 4'hF, 1'b1, 1'b0});
        end
        rst_n    = 1'b1;
        t        = 0;
        m_active = 16'h0;
        m_shadow = 16'h0;
        m_pend   = 1'b0;
    endtask

    task automatic expect_at(input string name, input int cyc, input logic [9:0] exp);
        if (cyc < t) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL %s schedule: cycle %0d already passed, now t=%0d", name, cyc, t);
        end else begin
            while (t < cyc) tick(1'b0, 16'h0);
            check(name, dut_out(), exp);
        end
    endtask

    task automatic add_vec(input int cyc, input logic ld, input logic [15:0] d,
                           input logic [3:0] nib, input logic [3:0] an,
                           input logic blank, input logic frame, input string name);
        vec_t v;
        v.cyc = cyc; v.ld = ld; v.d = d; v.nib = nib; v.an = an;
        v.blank = blank; v.frame = frame; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus();
        logic [31:0] r;
        logic        ld;
        foreach (vecs[i]) begin
            expect_at(vecs[i].name, vecs[i].cyc,
                      {vecs[i].nib, vecs[i].an, vecs[i].blank, vecs[i].frame});
            if (vecs[i].ld) tick(1'b1, vecs[i].d);
        end

        // Mid-frame reset must drop the active value and restart at digit 0.
        do_reset(3);
        tick(1'b1, 16'h1234);
        expect_at("act_1234_d2", 50, {4'h2, 4'hB, 1'b0, 1'b0});
        do_reset(1);
        expect_at("post_rst_d0", 2, {4'h0, 4'hE, 1'b0, 1'b0});
        expect_at("post_rst_frame", 32, {4'h0, 4'hF, 1'b1, 1'b1});

        tick(1'b1, 16'h1111);
        tick(1'b1, 16'h2222);
        expect_at("last_load_wins", 64, {4'h2, 4'hF, 1'b1, 1'b1});
        expect_at("last_load_show", 66, {4'h2, 4'hE, 1'b0, 1'b0});

        tick(1'b1, 16'h0030);
        expect_at("lzb_d0", 98, {4'h0, 4'hE, 1'b0, 1'b0});
        expect_at("lzb_d1", 106, {4'h3, 4'hD, 1'b0, 1'b0});
        expect_at("lzb_d2", 114, {4'h0, (LZB ? 4'hF : 4'hB), LZB, 1'b0});
        expect_at("lzb_d3", 122, {4'h0, (LZB ? 4'hF : 4'h7), LZB, 1'b0});

        for (int i = 0; i < 800; i++) begin
            r  = $urandom;
            ld = ($urandom_range(0, 15) == 0) ||
                 ((t % FRAME == FRAME - 1) && ($urandom_range(0, 1) == 1));
            tick(ld, r[15:0]);
        end
    endtask

    initial begin
        add_vec(  0, 1'b1, 16'h1234, 4'h0, 4'hF, 1'b1, 1'b0, "reset_state");
        add_vec(  2, 1'b0, 16'h0000, 4'h0, 4'hE, 1'b0, 1'b0, "first_show_d0");
        add_vec( 10, 1'b0, 16'h0000, 4'h0, (LZB ? 4'hF : 4'hD), LZB, 1'b0, "zero_d1");
        add_vec( 32, 1'b0, 16'h0000, 4'h4, 4'hF, 1'b1, 1'b1, "frame1_blank");
        add_vec( 33, 1'b0, 16'h0000, 4'h4, 4'hF, 1'b1, 1'b0, "frame1_pulse_end");
        add_vec( 34, 1'b0, 16'h0000, 4'h4, 4'hE, 1'b0, 1'b0, "d0_show_4");
        add_vec( 39, 1'b0, 16'h0000, 4'h4, 4'hE, 1'b0, 1'b0, "d0_show_last");
        add_vec( 40, 1'b0, 16'h0000, 4'h3, 4'hF, 1'b1, 1'b0, "d1_blank");
        add_vec( 42, 1'b0, 16'h0000, 4'h3, 4'hD, 1'b0, 1'b0, "d1_show_3");
        add_vec( 50, 1'b1, 16'h5678, 4'h2, 4'hB, 1'b0, 1'b0, "d2_show_2_load");
        add_vec( 58, 1'b0, 16'h0000, 4'h1, 4'h7, 1'b0, 1'b0, "d3_no_tear");
        add_vec( 64, 1'b0, 16'h0000, 4'h8, 4'hF, 1'b1, 1'b1, "frame2_d0_8");
        add_vec( 66, 1'b0, 16'h0000, 4'h8, 4'hE, 1'b0, 1'b0, "d0_show_8");
        add_vec( 74, 1'b0, 16'h0000, 4'h7, 4'hD, 1'b0, 1'b0, "d1_show_7");
        add_vec( 82, 1'b0, 16'h0000, 4'h6, 4'hB, 1'b0, 1'b0, "d2_show_6");
        add_vec( 95, 1'b1, 16'hABCD, 4'h5, 4'h7, 1'b0, 1'b0, "wrap_load");
        add_vec( 96, 1'b0, 16'h0000, 4'hD, 4'hF, 1'b1, 1'b1, "bypass_d0_D");
        add_vec( 98, 1'b0, 16'h0000, 4'hD, 4'hE, 1'b0, 1'b0, "bypass_show_D");
        add_vec(106, 1'b0, 16'h0000, 4'hC, 4'hD, 1'b0, 1'b0, "bypass_show_C");
        add_vec(127, 1'b0, 16'h0000, 4'hA, 4'h7, 1'b0, 1'b0, "no_frame_early");
        add_vec(128, 1'b0, 16'h0000, 4'hD, 4'hF, 1'b1, 1'b1, "held_active");

        do_reset(3);
        applyStimulus();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
